// File: rtl/sramc_ahb_arbiter.sv
// sramc_ahb_arbiter: two-master AHB-Lite arbiter in front of the SRAM
// controller slave.
//
// The grant (gnt) selects which master's address phase reaches the slave.
// The data-phase owner (dgnt) trails gnt by one accepted transfer and
// selects the write data. A fixed-length burst keeps the grant until its
// last beat. An undefined-length INCR keeps the grant for at most MAX_HOLD
// beats.
//
// Handshake: hready is the only transfer qualifier. A transfer is accepted,
// and every register in this block advances, only on a rising hclk edge
// with hready=1. With hready=0 all state holds, including in mid-burst.
//
// Optional feature: define SRAMC_ARB_STATS_EN to add per-master counters
// of accepted transfers (m0_xfer_cnt, m1_xfer_cnt) and a stats_clr input.
//
// arb_state exposes the FSM state (0=ARB, 1=BURST, 2=HOLD) for observation.

module sramc_ahb_arbiter #(
  parameter int DEFAULT_MASTER = 0,
  parameter int ARB_MODE       = 0,
  parameter int MAX_HOLD       = 16
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        m0_hbusreq,
  input  logic        m1_hbusreq,
  output logic        m0_hgrant,
  output logic        m1_hgrant,
  input  logic        m0_hsel,
  input  logic        m1_hsel,
  input  logic [1:0]  m0_htrans,
  input  logic [1:0]  m1_htrans,
  input  logic [1:0]  m0_hsize,
  input  logic [1:0]  m1_hsize,
  input  logic [3:0]  m0_hburst,
  input  logic [3:0]  m1_hburst,
  input  logic        m0_hwrite,
  input  logic        m1_hwrite,
  input  logic [31:0] m0_haddr,
  input  logic [31:0] m1_haddr,
  input  logic [31:0] m0_hwdata,
  input  logic [31:0] m1_hwdata,
  input  logic        hready,
  output logic        s_hsel,
  output logic [1:0]  s_htrans,
  output logic [1:0]  s_hsize,
  output logic [3:0]  s_hburst,
  output logic        s_hwrite,
  output logic [31:0] s_haddr,
  output logic [31:0] s_hwdata,
  output logic        hmaster,
  output logic [1:0]  arb_state
`ifdef SRAMC_ARB_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] m0_xfer_cnt,
  output logic [15:0] m1_xfer_cnt
`endif
);

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic       DM       = (DEFAULT_MASTER != 0);
  localparam bit         RR       = (ARB_MODE != 0);
  localparam logic [7:0] HOLD_CNT = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BURST = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t     state;
  logic       gnt;
  logic       dgnt;
  logic       last;
  logic [7:0] cnt;

  logic [1:0] own_htrans;
  logic [2:0] own_hburst;
  logic [7:0] burst_cnt;
  logic       arb_pick;
  logic       arb_now;
  logic       start_fixed;
  logic       start_incr;
  logic       own_seq;

  // Address/control of the current address-phase owner, used by the FSM.
  always_comb begin
    own_htrans = gnt ? m1_htrans : m0_htrans;
    own_hburst = gnt ? m1_hburst[2:0] : m0_hburst[2:0];
  end

  // Remaining SEQ beats after the NONSEQ of a fixed-length burst.
  always_comb begin
    burst_cnt = 8'd0;
    case (own_hburst)
      3'd2, 3'd3: burst_cnt = 8'd3;
      3'd4, 3'd5: burst_cnt = 8'd7;
      3'd6, 3'd7: burst_cnt = 8'd15;
      default:    burst_cnt = 8'd0;
    endcase
  end

  // Winner of a fresh arbitration round; parks on DEFAULT_MASTER when idle.
  always_comb begin
    arb_pick = DM;
    if (m0_hbusreq && m1_hbusreq) begin
      arb_pick = RR ? ~last : 1'b0;
    end else if (m0_hbusreq) begin
      arb_pick = 1'b0;
    end else if (m1_hbusreq) begin
      arb_pick = 1'b1;
    end
  end

  // An early-terminated fixed burst (IDLE or NONSEQ) is arbitrated on the
  // same edge, exactly as if the FSM were already in ARB.
  assign arb_now = (state != ST_BURST && state != ST_HOLD) ||
                   (state == ST_BURST &&
                    (own_htrans == HTRANS_IDLE || own_htrans == HTRANS_NONSEQ));
  assign start_fixed = (own_htrans == HTRANS_NONSEQ) && (own_hburst >= 3'd2);
  assign start_incr  = (own_htrans == HTRANS_NONSEQ) && (own_hburst == 3'd1);
  assign own_seq     = (own_htrans == HTRANS_SEQ);

  // Grant FSM: arbitration, burst locking and the data-phase owner pipeline.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state <= ST_ARB;
      gnt   <= DM;
      dgnt  <= DM;
      last  <= DM;
      cnt   <= 8'd0;
    end else if (hready) begin
      dgnt <= gnt;
      if (arb_now) begin
        if (start_fixed) begin
          state <= ST_BURST;
          cnt   <= burst_cnt;
        end else if (start_incr) begin
          state <= ST_HOLD;
          cnt   <= HOLD_CNT;
        end else begin
          state <= ST_ARB;
          cnt   <= 8'd0;
          if (arb_pick != gnt) begin
            gnt  <= arb_pick;
            last <= arb_pick;
          end
        end
      end else if (state == ST_BURST) begin
        // BUSY leaves the count untouched.
        if (own_seq) begin
          if (cnt == 8'd1) begin
            state <= ST_ARB;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
      end else begin
        // HOLD: only the owner's IDLE or the beat limit ends the lock.
        if (own_htrans == HTRANS_IDLE) begin
          state <= ST_ARB;
          cnt   <= 8'd0;
        end else if (own_seq) begin
          if (cnt == 8'd1) begin
            state <= ST_ARB;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
      end
    end
  end

  // Slave-side address phase follows gnt, write data follows dgnt.
  always_comb begin
    s_hsel   = gnt ? m1_hsel   : m0_hsel;
    s_htrans = gnt ? m1_htrans : m0_htrans;
    s_hsize  = gnt ? m1_hsize  : m0_hsize;
    s_hburst = gnt ? m1_hburst : m0_hburst;
    s_hwrite = gnt ? m1_hwrite : m0_hwrite;
    s_haddr  = gnt ? m1_haddr  : m0_haddr;
    s_hwdata = dgnt ? m1_hwdata : m0_hwdata;
  end

  assign hmaster   = gnt;
  assign m0_hgrant = ~gnt;
  assign m1_hgrant = gnt;
  assign arb_state = state;

`ifdef SRAMC_ARB_STATS_EN
  logic xfer_ok;
  assign xfer_ok = hready && s_hsel && s_htrans[1];

  // Saturating per-owner counters of accepted NONSEQ/SEQ transfers.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      m0_xfer_cnt <= 16'd0;
      m1_xfer_cnt <= 16'd0;
    end else if (stats_clr) begin
      m0_xfer_cnt <= 16'd0;
      m1_xfer_cnt <= 16'd0;
    end else if (xfer_ok) begin
      if (!gnt && m0_xfer_cnt != 16'hFFFF) m0_xfer_cnt <= m0_xfer_cnt + 16'd1;
      if (gnt && m1_xfer_cnt != 16'hFFFF)  m1_xfer_cnt <= m1_xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sramc_ahb_arbiter.sv
// tb_sramc_ahb_arbiter: two arbiter instances share one set of master
// inputs: u_fp (fixed priority, DEFAULT_MASTER=0, MAX_HOLD=16) and
// u_rr (round-robin, DEFAULT_MASTER=1, MAX_HOLD=4). A behavioural model
// tracks owner, data owner and remaining locked beats for each instance.

module tb_sramc_ahb_arbiter;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  // ---------------- clock / reset and shared master inputs ----------------
  logic        hclk;
  logic        hreset;
  logic        hready;
  logic        m0_hbusreq, m1_hbusreq, m0_hsel, m1_hsel, m0_hwrite, m1_hwrite;
  logic [1:0]  m0_htrans, m1_htrans, m0_hsize, m1_hsize;
  logic [3:0]  m0_hburst, m1_hburst;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
`ifdef SRAMC_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] fp_c0, fp_c1, rr_c0, rr_c1;
`endif

  initial hclk = 1'b1;
  always #5 hclk = ~hclk;

  // ---------------- DUT outputs ----------------
  logic        fp_g0, fp_g1, fp_hsel, fp_hwrite, fp_hmaster;
  logic [1:0]  fp_htrans, fp_hsize, fp_state;
  logic [3:0]  fp_hburst;
  logic [31:0] fp_haddr, fp_hwdata;
  logic        rr_g0, rr_g1, rr_hsel, rr_hwrite, rr_hmaster;
  logic [1:0]  rr_htrans, rr_hsize, rr_state;
  logic [3:0]  rr_hburst;
  logic [31:0] rr_haddr, rr_hwdata;

  sramc_ahb_arbiter #(.DEFAULT_MASTER(0), .ARB_MODE(0), .MAX_HOLD(16)) u_fp (
    .hclk(hclk), .hreset(hreset),
    .m0_hbusreq(m0_hbusreq), .m1_hbusreq(m1_hbusreq),
    .m0_hgrant(fp_g0), .m1_hgrant(fp_g1),
    .m0_hsel(m0_hsel), .m1_hsel(m1_hsel),
    .m0_htrans(m0_htrans), .m1_htrans(m1_htrans),
    .m0_hsize(m0_hsize), .m1_hsize(m1_hsize),
    .m0_hburst(m0_hburst), .m1_hburst(m1_hburst),
    .m0_hwrite(m0_hwrite), .m1_hwrite(m1_hwrite),
    .m0_haddr(m0_haddr), .m1_haddr(m1_haddr),
    .m0_hwdata(m0_hwdata), .m1_hwdata(m1_hwdata),
    .hready(hready),
    .s_hsel(fp_hsel), .s_htrans(fp_htrans), .s_hsize(fp_hsize),
    .s_hburst(fp_hburst), .s_hwrite(fp_hwrite), .s_haddr(fp_haddr),
    .s_hwdata(fp_hwdata), .hmaster(fp_hmaster), .arb_state(fp_state)
`ifdef SRAMC_ARB_STATS_EN
    , .stats_clr(stats_clr), .m0_xfer_cnt(fp_c0), .m1_xfer_cnt(fp_c1)
`endif
  );

  sramc_ahb_arbiter #(.DEFAULT_MASTER(1), .ARB_MODE(1), .MAX_HOLD(4)) u_rr (
    .hclk(hclk), .hreset(hreset),
    .m0_hbusreq(m0_hbusreq), .m1_hbusreq(m1_hbusreq),
    .m0_hgrant(rr_g0), .m1_hgrant(rr_g1),
    .m0_hsel(m0_hsel), .m1_hsel(m1_hsel),
    .m0_htrans(m0_htrans), .m1_htrans(m1_htrans),
    .m0_hsize(m0_hsize), .m1_hsize(m1_hsize),
    .m0_hburst(m0_hburst), .m1_hburst(m1_hburst),
    .m0_hwrite(m0_hwrite), .m1_hwrite(m1_hwrite),
    .m0_haddr(m0_haddr), .m1_haddr(m1_haddr),
    .m0_hwdata(m0_hwdata), .m1_hwdata(m1_hwdata),
    .hready(hready),
    .s_hsel(rr_hsel), .s_htrans(rr_htrans), .s_hsize(rr_hsize),
    .s_hburst(rr_hburst), .s_hwrite(rr_hwrite), .s_haddr(rr_haddr),
    .s_hwdata(rr_hwdata), .hmaster(rr_hmaster), .arb_state(rr_state)
`ifdef SRAMC_ARB_STATS_EN
    , .stats_clr(stats_clr), .m0_xfer_cnt(rr_c0), .m1_xfer_cnt(rr_c1)
`endif
  );

  logic [76:0] obs [2];
  assign obs[0] = {fp_hmaster, fp_g0, fp_g1, fp_hsel, fp_htrans, fp_hsize,
                   fp_hburst, fp_hwrite, fp_haddr, fp_hwdata};
  assign obs[1] = {rr_hmaster, rr_g0, rr_g1, rr_hsel, rr_htrans, rr_hsize,
                   rr_hburst, rr_hwrite, rr_haddr, rr_hwdata};

  // ---------------- reference model ----------------
  int   p_mode [2] = '{0, 1};
  int   p_dm   [2] = '{0, 1};
  int   p_mh   [2] = '{16, 4};
  logic e_gnt  [2];
  logic e_dgnt [2];
  logic e_last [2];
  int   lock_left  [2];  // SEQ beats still owed to the owner; 0 = free
  bit   lock_fixed [2];  // 1 = fixed-length burst, 0 = undefined INCR
`ifdef SRAMC_ARB_STATS_EN
  int   e_xfer [2][2];
`endif
  int   vecs;
  int   errs;

  function automatic logic pick(int k);
    if (m0_hbusreq && m1_hbusreq) return (p_mode[k] == 1) ? ~e_last[k] : 1'b0;
    if (m0_hbusreq) return 1'b0;
    if (m1_hbusreq) return 1'b1;
    return (p_dm[k] != 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      e_gnt[k]      = (p_dm[k] != 0);
      e_dgnt[k]     = (p_dm[k] != 0);
      e_last[k]     = (p_dm[k] != 0);
      lock_left[k]  = 0;
      lock_fixed[k] = 1'b0;
`ifdef SRAMC_ARB_STATS_EN
      e_xfer[k][0] = 0;
      e_xfer[k][1] = 0;
`endif
    end
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    if (!hreset) begin
      model_reset();
      return;
    end
`ifdef SRAMC_ARB_STATS_EN
    if (stats_clr) begin
      for (int k = 0; k < 2; k++) begin
        e_xfer[k][0] = 0;
        e_xfer[k][1] = 0;
      end
    end
`endif
    if (!hready) return;
    for (int k = 0; k < 2; k++) begin
      logic       o;
      logic       osel;
      logic       np;
      logic [1:0] ot;
      logic [2:0] ob;
      bit         free_now;
      o    = e_gnt[k];
      ot   = o ? m1_htrans : m0_htrans;
      ob   = o ? m1_hburst[2:0] : m0_hburst[2:0];
      osel = o ? m1_hsel : m0_hsel;
`ifdef SRAMC_ARB_STATS_EN
      if (!stats_clr && osel && ot[1] && e_xfer[k][o] < 65535) e_xfer[k][o]++;
`else
      if (osel) begin end
`endif
      e_dgnt[k] = o;
      free_now  = (lock_left[k] == 0);
      if (!free_now) begin
        if (ot == T_SEQ) begin
          lock_left[k]--;
        end else if (ot == T_IDLE) begin
          lock_left[k] = 0;
          free_now = lock_fixed[k];
        end else if (ot == T_NONSEQ && lock_fixed[k]) begin
          lock_left[k] = 0;
          free_now = 1'b1;
        end
      end
      if (free_now) begin
        if (ot == T_NONSEQ && ob >= 3'd2) begin
          lock_left[k]  = (ob >= 3'd6) ? 15 : (ob >= 3'd4) ? 7 : 3;
          lock_fixed[k] = 1'b1;
        end else if (ot == T_NONSEQ && ob == 3'd1) begin
          lock_left[k]  = p_mh[k] - 1;
          lock_fixed[k] = 1'b0;
        end else begin
          np = pick(k);
          if (np != e_gnt[k]) e_last[k] = np;
          e_gnt[k] = np;
        end
      end
    end
  endtask

  function automatic logic [76:0] exp_vec(int k);
    logic [31:0] wd;
    wd = e_dgnt[k] ? m1_hwdata : m0_hwdata;
    if (e_gnt[k])
      return {1'b1, 1'b0, 1'b1, m1_hsel, m1_htrans, m1_hsize, m1_hburst,
              m1_hwrite, m1_haddr, wd};
    return {1'b0, 1'b1, 1'b0, m0_hsel, m0_htrans, m0_hsize, m0_hburst,
            m0_hwrite, m0_haddr, wd};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(negedge hclk);
  endtask

  task automatic set_idle();
    hready = 1'b1;
    m0_hbusreq = 1'b0; m1_hbusreq = 1'b0;
    m0_hsel = 1'b1;    m1_hsel = 1'b1;
    m0_htrans = T_IDLE; m1_htrans = T_IDLE;
    m0_hsize = 2'd2;   m1_hsize = 2'd2;
    m0_hburst = 4'd0;  m1_hburst = 4'd0;
    m0_hwrite = 1'b0;  m1_hwrite = 1'b0;
    m0_haddr = 32'h0;  m1_haddr = 32'h0;
    m0_hwdata = $urandom; m1_hwdata = $urandom;
`ifdef SRAMC_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  task automatic rand_inputs();
    hready     = ($urandom_range(0, 3) != 0);
    m0_hbusreq = ($urandom_range(0, 2) != 0);
    m1_hbusreq = ($urandom_range(0, 2) != 0);
    m0_hsel    = 1'($urandom_range(0, 1));
    m1_hsel    = 1'($urandom_range(0, 1));
    m0_htrans  = 2'($urandom_range(0, 3));
    m1_htrans  = 2'($urandom_range(0, 3));
    m0_hsize   = 2'($urandom_range(0, 3));
    m1_hsize   = 2'($urandom_range(0, 3));
    m0_hburst  = 4'($urandom_range(0, 15));
    m1_hburst  = 4'($urandom_range(0, 15));
    m0_hwrite  = 1'($urandom_range(0, 1));
    m1_hwrite  = 1'($urandom_range(0, 1));
    m0_haddr   = $urandom;
    m1_haddr   = $urandom;
    m0_hwdata  = $urandom;
    m1_hwdata  = $urandom;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    hreset = 1'b0;
    set_idle();
    m0_haddr = 32'h1234_5678;
    m1_haddr = 32'h8765_4321;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (obs[k] !== exp_vec(k)) begin
        errs++;
        $display("FAIL reset_outputs inst%0d got %h want %h", k, obs[k], exp_vec(k));
      end
    end
    vecs++;
    if ({fp_hmaster, fp_g0, fp_g1} !== 3'b010) begin
      errs++;
      $display("FAIL reset_fp_grant got %b want 010", {fp_hmaster, fp_g0, fp_g1});
    end
    vecs++;
    if ({rr_hmaster, rr_g0, rr_g1} !== 3'b101) begin
      errs++;
      $display("FAIL reset_rr_grant got %b want 101", {rr_hmaster, rr_g0, rr_g1});
    end
    m0_haddr = 32'hCAFE_0000;
    #1;
    vecs++;
    if (fp_haddr !== 32'hCAFE_0000) begin
      errs++;
      $display("FAIL reset_haddr_track got %h want cafe0000", fp_haddr);
    end
    hreset = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (obs[k] !== exp_vec(k)) begin
        errs++;
        $display("FAIL reset_park inst%0d got %h want %h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_m1_incr4();
    logic [1:0]  seq [8] = '{T_NONSEQ, T_SEQ, T_BUSY, T_BUSY, T_SEQ, T_SEQ, T_IDLE, T_IDLE};
    logic [31:0] a;
    set_idle();
    m1_hbusreq = 1'b1;
    m1_hwrite  = 1'b1;
    tick();
    vecs++;
    if (fp_hmaster !== 1'b1) begin
      errs++;
      $display("FAIL incr4_grant got %b want 1", fp_hmaster);
    end
    a = 32'h100;
    for (int i = 0; i < 8; i++) begin
      m1_htrans = seq[i];
      m1_hburst = 4'd3;
      m1_haddr  = a;
      m1_hwdata = $urandom;
      if (seq[i][1]) a = a + 32'd4;
      tick();
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (obs[k] !== exp_vec(k)) begin
          errs++;
          $display("FAIL incr4_beat%0d inst%0d got %h want %h", i, k, obs[k], exp_vec(k));
        end
      end
      vecs++;
      if (fp_hmaster !== 1'b1 || fp_hwdata !== m1_hwdata) begin
        errs++;
        $display("FAIL incr4_hold beat%0d got master %b data %h want master 1 data %h",
                 i, fp_hmaster, fp_hwdata, m1_hwdata);
      end
    end
  endtask

  task automatic test_stall_incr8();
    int b;
    set_idle();
    m0_hbusreq = 1'b1;
    m1_hbusreq = 1'b1;
    m0_htrans  = T_NONSEQ;
    m1_hburst  = 4'd5;
    b = 0;
    for (int i = 0; i < 11; i++) begin
      hready    = !(i >= 4 && i < 7);
      m1_htrans = (b == 0) ? T_NONSEQ : T_SEQ;
      m1_haddr  = 32'h200 + 32'(4 * b);
      m1_hwdata = $urandom;
      m0_haddr  = $urandom;
      tick();
      if (hready) b++;
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (obs[k] !== exp_vec(k)) begin
          errs++;
          $display("FAIL incr8_cycle%0d inst%0d got %h want %h", i, k, obs[k], exp_vec(k));
        end
      end
      vecs++;
      if (fp_hmaster !== 1'b1) begin
        errs++;
        $display("FAIL incr8_keep cycle%0d got %b want 1", i, fp_hmaster);
      end
    end
    hready    = 1'b1;
    m1_htrans = T_IDLE;
    tick();
    vecs++;
    if (fp_hmaster !== 1'b0) begin
      errs++;
      $display("FAIL incr8_handover got %b want 0", fp_hmaster);
    end
  endtask

  task automatic test_rr_alternate();
    logic want;
    set_idle();
    m0_hbusreq = 1'b1; m1_hbusreq = 1'b1;
    m0_htrans  = T_NONSEQ; m1_htrans = T_NONSEQ;
    tick();
    tick();
    want = e_gnt[1];
    for (int i = 0; i < 6; i++) begin
      m0_haddr = $urandom; m1_haddr = $urandom;
      m0_hwdata = $urandom; m1_hwdata = $urandom;
      tick();
      want = ~want;
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (obs[k] !== exp_vec(k)) begin
          errs++;
          $display("FAIL rr_cycle%0d inst%0d got %h want %h", i, k, obs[k], exp_vec(k));
        end
      end
      vecs++;
      if (rr_hmaster !== want) begin
        errs++;
        $display("FAIL rr_alternate cycle%0d got %b want %b", i, rr_hmaster, want);
      end
    end
  endtask

  task automatic test_incr_hold();
    set_idle();
    m0_hbusreq = 1'b1;
    tick();
    m1_hbusreq = 1'b1;
    for (int b = 0; b < 20; b++) begin
      m0_hbusreq = (b == 0);
      m0_htrans  = (b == 0) ? T_NONSEQ : T_SEQ;
      m0_hburst  = 4'd1;
      m0_haddr   = 32'h400 + 32'(4 * b);
      tick();
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (obs[k] !== exp_vec(k)) begin
          errs++;
          $display("FAIL hold_beat%0d inst%0d got %h want %h", b, k, obs[k], exp_vec(k));
        end
      end
      vecs++;
      if (fp_hmaster !== ((b >= 16) ? 1'b1 : 1'b0)) begin
        errs++;
        $display("FAIL hold_limit beat%0d got %b want %b", b, fp_hmaster, (b >= 16));
      end
    end
    // Second INCR from m0, aborted by reset part-way through.
    set_idle();
    m0_hbusreq = 1'b1;
    tick();
    m1_hbusreq = 1'b1;
    for (int b = 0; b < 5; b++) begin
      m0_hbusreq = (b == 0);
      m0_htrans  = (b == 0) ? T_NONSEQ : T_SEQ;
      m0_hburst  = 4'd1;
      m0_haddr   = 32'h800 + 32'(4 * b);
      tick();
    end
    #2 hreset = 1'b0;
    #1 model_reset();
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (obs[k] !== exp_vec(k)) begin
        errs++;
        $display("FAIL async_reset inst%0d got %h want %h", k, obs[k], exp_vec(k));
      end
    end
    vecs++;
    if ({fp_state, rr_state, fp_hmaster, rr_hmaster} !== 6'b0000_01) begin
      errs++;
      $display("FAIL async_reset_state got %b want 000001",
               {fp_state, rr_state, fp_hmaster, rr_hmaster});
    end
    tick();
    hreset = 1'b1;
    m0_haddr = 32'h814;
    tick();
    vecs++;
    if (fp_hmaster !== 1'b1) begin
      errs++;
      $display("FAIL reset_abort_rearb got %b want 1", fp_hmaster);
    end
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (obs[k] !== exp_vec(k)) begin
        errs++;
        $display("FAIL post_reset inst%0d got %h want %h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      hreset = ($urandom_range(0, 79) != 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (obs[k] !== exp_vec(k)) begin
          errs++;
          $display("FAIL random_cycle%0d inst%0d got %h want %h", i, k, obs[k], exp_vec(k));
        end
      end
    end
    hreset = 1'b1;
    set_idle();
    tick();
  endtask

`ifdef SRAMC_ARB_STATS_EN
  task automatic test_stats();
    set_idle();
    hreset = 1'b0;
    tick();
    hreset = 1'b1;
    m0_hbusreq = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      m0_htrans = T_NONSEQ;
      m0_hwrite = 1'b1;
      m0_haddr  = 32'h40 + 32'(4 * i);
      tick();
    end
    m0_htrans  = T_IDLE;
    m0_hbusreq = 1'b0;
    m1_hbusreq = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      m1_htrans = T_NONSEQ;
      m1_hwrite = 1'b0;
      m1_haddr  = 32'h80 + 32'(4 * i);
      tick();
    end
    m1_htrans = T_IDLE;
    tick();
    vecs++;
    if (fp_c0 !== 16'd5 || fp_c1 !== 16'd3) begin
      errs++;
      $display("FAIL stats_count got %0d/%0d want 5/3", fp_c0, fp_c1);
    end
    vecs++;
    if (rr_c0 !== 16'(e_xfer[1][0]) || rr_c1 !== 16'(e_xfer[1][1])) begin
      errs++;
      $display("FAIL stats_count_rr got %0d/%0d want %0d/%0d",
               rr_c0, rr_c1, e_xfer[1][0], e_xfer[1][1]);
    end
    stats_clr = 1'b1;
    m1_htrans = T_NONSEQ;
    tick();
    stats_clr = 1'b0;
    m1_htrans = T_IDLE;
    vecs++;
    if ({fp_c0, fp_c1, rr_c0, rr_c1} !== 64'd0) begin
      errs++;
      $display("FAIL stats_clear got %0d/%0d/%0d/%0d want 0/0/0/0",
               fp_c0, fp_c1, rr_c0, rr_c1);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    vecs   = 0;
    errs   = 0;
    hreset = 1'b0;
    set_idle();
    model_reset();
    @(negedge hclk);
    test_reset();
    test_m1_incr4();
    test_stall_incr8();
    test_rr_alternate();
    test_incr_hold();
    test_random();
`ifdef SRAMC_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sramc_ahb_arbiter.md
Name: sramc_ahb_arbiter

Overview:
- Two-master AHB-Lite arbiter in front of the single SRAM controller slave.
- Grants the bus to one master and muxes that master's address/control phase to the slave.
- Muxes write data according to the data-phase owner.
- Holds the grant for the whole of a fixed-length burst, or for a bounded undefined-length INCR.
- Slave-side hrdata/hresp/hready are broadcast to both masters outside this block.

Parameters:
- DEFAULT_MASTER, 0: master parked on the bus when nobody requests; reset owner.
- ARB_MODE, 0: 0 = fixed priority (m0 highest), 1 = round-robin.
- MAX_HOLD, 16: maximum beats an undefined-length INCR keeps the grant before forced re-arbitration (range 2..255).

Ports:
- hclk  input  1  clock.
- hreset  input  1  asynchronous active-low reset.
- m0_hbusreq / m1_hbusreq  input  1  bus request per master.
- m0_hgrant / m1_hgrant  output  1  grant, one-hot of gnt.
- m0_hsel / m1_hsel  input  1  master slave-select.
- m0_htrans / m1_htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- m0_hsize / m1_hsize  input  2  transfer size.
- m0_hburst / m1_hburst  input  4  bits[2:0] carry AHB HBURST encoding; bit3 passed through.
- m0_hwrite / m1_hwrite  input  1  write flag.
- m0_haddr / m1_haddr  input  32  address.
- m0_hwdata / m1_hwdata  input  32  write data.
- hready  input  1  slave hready, a transfer-complete qualifier.
- s_hsel, s_htrans, s_hsize, s_hburst, s_hwrite, s_haddr  output  1/2/2/4/1/32  muxed address phase.
- s_hwdata  output  32  muxed write data.
- hmaster  output  1  current address-phase owner (gnt).

Behaviour:
- Registers:
  - gnt (address owner); dgnt (data owner).
  - state in {ARB, BURST, HOLD}.
  - beat counter cnt, 8 bits.
  - last (last granted master, used for round-robin).
- Reset (async, hreset=0): gnt=dgnt=last=DEFAULT_MASTER; state=ARB; cnt=0; hgrant one-hot of DEFAULT_MASTER; hmaster=DEFAULT_MASTER. s_* follow the combinational mux of DEFAULT_MASTER inputs.
- Muxes:
  - s_hsel/htrans/hsize/hburst/hwrite/haddr = gnt-selected master inputs, combinational, zero latency.
  - s_hwdata = dgnt-selected hwdata.
  - dgnt <= gnt on every posedge with hready=1.
- All state updates occur only on posedge with hready=1. With hready=0 everything holds, including mid-burst.
- ARB state, evaluated on each hready edge using the owner's htrans and hburst[2:0]:
  - Owner NONSEQ with hburst 2..7 (WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16): cnt=len-1 (3/7/15), go BURST, gnt unchanged.
  - Owner NONSEQ with hburst 1 (INCR): cnt=MAX_HOLD-1, go HOLD, gnt unchanged.
  - Otherwise (IDLE, or NONSEQ SINGLE): re-arbitrate.
    - Fixed priority: m0 if m0_hbusreq, else m1 if m1_hbusreq, else DEFAULT_MASTER.
    - Round-robin: if both request, pick !last; otherwise the sole requester, else DEFAULT_MASTER.
    - On gnt change, last <= new gnt.
- BURST state:
  - Owner SEQ decrements cnt; BUSY holds cnt.
  - When a SEQ is accepted with cnt==1, the next state is ARB, so re-arbitration happens at the edge after the final beat's address phase.
  - Owner IDLE or NONSEQ mid-burst (early termination) returns to ARB immediately, with the ARB rules applied on that same edge.
- HOLD state:
  - SEQ decrements cnt.
  - Return to ARB when owner htrans==IDLE, or on accepting SEQ with cnt==1 (MAX_HOLD reached).
  - The other master's hbusreq does not shorten HOLD.
- Boundary cases:
  - Both requests drop: park on DEFAULT_MASTER at the next ARB edge.
  - Requester deasserts hbusreq while owning in ARB: loses grant at that edge if the other master requests, or if it is not DEFAULT_MASTER.
  - hburst[2:0]==0 is treated as SINGLE.
  - Reset mid-burst aborts immediately to reset values.

Optional Feature:
- Macro: SRAMC_ARB_STATS_EN.
- When defined:
  - Adds outputs m0_xfer_cnt and m1_xfer_cnt, 16 bits each.
  - Each counts accepted NONSEQ/SEQ transfers (hready=1, s_hsel=1) per gnt owner.
  - Counters saturate at 0xFFFF and reset to 0.
  - Adds input stats_clr, which synchronously zeroes both counters and takes priority over increment.
- When undefined: no counters, no extra ports; behaviour otherwise identical.

Test Plan:
- Reset, no requests -> hmaster=0, m0_hgrant=1, m1_hgrant=0; s_haddr tracks m0_haddr.
- m1 only requests; m1 issues INCR4 at 0x100 -> gnt=1 after the first hready edge; grant held for 4 beats, including 2 inserted BUSY cycles; m1 data appears on s_hwdata one cycle after each address.
- Both request, ARB_MODE=0, m1 owns an INCR8 with hready stalled 3 cycles mid-burst -> m1 keeps the grant for all 8 beats, then m0 is granted at the next edge.
- ARB_MODE=1, both requesting SINGLE transfers continuously -> hmaster alternates 0,1,0,1 on successive hready edges.
- m0 issues INCR (undefined) for 20 beats with MAX_HOLD=16, m1 requesting -> gnt switches to m1 after beat 16; hreset asserted mid-burst -> immediate return to reset values.
- SRAMC_ARB_STATS_EN: 5 m0 writes and 3 m1 reads -> m0_xfer_cnt=5, m1_xfer_cnt=3; stats_clr pulse -> both 0.
